// File: rtl/slave_port_pkg.sv
// Shared constants and types for the serial slave port.
package slave_port_pkg;

   localparam int DEF_ADDR_W  = 12;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_BURST_W = 13;

   // Header length in valid cycles: address and burst travel in parallel,
   // so the longer of the two fields sets the header length.
   localparam int HDR_BITS = 13;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      WDATA,
      RFETCH,
      RDATA,
      DONE
   } state_t;

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous RAM, one cycle read latency, contents not reset.
module slave_mem #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write on we; read returns the old word at the same edge.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/slave_port.sv
// Serial slave responder: captures address/burst header, then writes
// serial words into local memory or streams stored words back LSB first.
module slave_port
   import slave_port_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int BURST_W = DEF_BURST_W
) (
   input  logic clk,
   input  logic reset,
   input  logic read_en,
   input  logic write_en,
   input  logic master_ready,
   input  logic master_valid,
   input  logic rx_done_in,
   input  logic rx_address,
   input  logic rx_burst,
   input  logic rx_data,
   output logic slave_valid,
   output logic slave_ready,
   output logic tx_data
);

   localparam int HC_W = $clog2(HDR_BITS + 1);
   localparam int BC_W = $clog2(DATA_W);
   localparam logic [HC_W-1:0] ADDR_BITS_C  = HC_W'(ADDR_W);
   localparam logic [HC_W-1:0] BURST_BITS_C = HC_W'(BURST_W);
   localparam logic [HC_W-1:0] HDR_LAST     = HC_W'(HDR_BITS - 1);
   localparam logic [BC_W-1:0] BIT_LAST     = BC_W'(DATA_W - 1);

   state_t state, state_nxt;

   logic               op_write;
   logic [HC_W-1:0]    hdr_cnt;
   logic [HC_W-1:0]    hdr_idx;
   logic [ADDR_W-1:0]  addr;
   logic [BURST_W-1:0] burst;
   logic [BURST_W-1:0] word_cnt;
   logic [BC_W-1:0]    bit_cnt;
   logic [DATA_W-2:0]  rx_sh;
   logic [DATA_W-1:0]  tx_sh;
   logic               slave_ready_q;

   logic               start;
   logic               abort;
   logic               last_word;
   logic               hdr_step;
   logic               wr_step;
   logic               rd_step;
   logic               word_end;
   logic               ready_nxt;

   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic [DATA_W-1:0]  mem_rdata;

   assign start     = master_valid & (read_en ^ write_en);
   assign abort     = (state != IDLE) & rx_done_in;
   // A zero burst count still moves one word.
   assign last_word = (burst == '0) || (word_cnt == burst - 1'b1);

   // While streaming a word out, the RAM is already addressed at the next
   // word so its data is ready during the following RFETCH cycle.
   assign mem_addr  = addr + ADDR_W'(word_cnt) + ADDR_W'(state == RDATA);
   assign mem_wdata = {rx_data, rx_sh};

   slave_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; an abort from the master overrides everything else.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = HDR;
            HDR:     if (master_valid && hdr_cnt == HDR_LAST)
                        state_nxt = op_write ? WDATA : RFETCH;
            WDATA:   if (master_valid && bit_cnt == BIT_LAST && last_word)
                        state_nxt = DONE;
            RFETCH:  state_nxt = RDATA;
            RDATA:   if (master_ready && bit_cnt == BIT_LAST)
                        state_nxt = last_word ? DONE : RFETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Per-cycle strobes and outputs derived from the current state.
   always_comb begin
      hdr_step = 1'b0;
      wr_step  = 1'b0;
      rd_step  = 1'b0;
      hdr_idx  = (state == IDLE) ? '0 : hdr_cnt;
      case (state)
         IDLE:    hdr_step = start;
         HDR:     hdr_step = master_valid & ~abort;
         WDATA:   wr_step  = master_valid & ~abort;
         RDATA:   rd_step  = master_ready & ~abort;
         default: ;
      endcase
      word_end    = (wr_step | rd_step) & (bit_cnt == BIT_LAST);
      mem_we      = wr_step & (bit_cnt == BIT_LAST);
      slave_valid = (state == RDATA) & master_ready;
      ready_nxt   = state_nxt inside {IDLE, HDR, WDATA};
   end

   // Header capture, bit/word counters and the rx/tx shift registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_write <= 1'b0;
         hdr_cnt  <= '0;
         addr     <= '0;
         burst    <= '0;
         word_cnt <= '0;
         bit_cnt  <= '0;
         rx_sh    <= '0;
         tx_sh    <= '0;
      end else begin
         if (hdr_step) begin
            if (hdr_idx < ADDR_BITS_C)  addr  <= {rx_address, addr[ADDR_W-1:1]};
            if (hdr_idx < BURST_BITS_C) burst <= {rx_burst, burst[BURST_W-1:1]};
            hdr_cnt <= hdr_idx + 1'b1;
            if (state == IDLE) begin
               op_write <= write_en;
               word_cnt <= '0;
               bit_cnt  <= '0;
            end
         end
         if (wr_step) begin
            rx_sh   <= mem_wdata[DATA_W-1:1];
            bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
         end
         if (state == RFETCH && !abort) begin
            tx_sh   <= mem_rdata;
            bit_cnt <= '0;
         end
         if (rd_step) begin
            tx_sh   <= {1'b0, tx_sh[DATA_W-1:1]};
            bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
         end
         if (word_end) begin
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

   // Registered ready, taken from the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slave_ready_q <= 1'b1;
      end else begin
         slave_ready_q <= ready_nxt;
      end
   end

   assign slave_ready = slave_ready_q;
   assign tx_data     = tx_sh[0];

endmodule

// File: tb/tb_slave_port.sv
// Scoreboard bench for slave_port: directed writes/reads, stalls, abort,
// reset during a read, illegal start and zero burst.
module tb_slave_port;
   import slave_port_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic read_en, write_en, master_ready, master_valid, rx_done_in;
   logic rx_address, rx_burst, rx_data;
   logic slave_valid, slave_ready, tx_data;

   int n_checks = 0;
   int n_fail   = 0;
   int acc      = 0;
   logic exp_q[$];
   logic [7:0] wbuf [8];
   logic [7:0] rbuf [8];

   always #5 clk = ~clk;

   slave_port dut (
      .clk          (clk),
      .reset        (reset),
      .read_en      (read_en),
      .write_en     (write_en),
      .master_ready (master_ready),
      .master_valid (master_valid),
      .rx_done_in   (rx_done_in),
      .rx_address   (rx_address),
      .rx_burst     (rx_burst),
      .rx_data      (rx_data),
      .slave_valid  (slave_valid),
      .slave_ready  (slave_ready),
      .tx_data      (tx_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every presented read bit is compared against the scoreboard.
   task automatic mon_loop();
      logic e;
      forever begin
         @(negedge clk);
         if (slave_valid === 1'b1) begin
            n_checks++;
            if (master_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL valid_without_ready: slave_valid=1 master_ready=%b", master_ready);
            end else if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_bit: tx_data=%b, no bit expected", tx_data);
            end else begin
               e = exp_q.pop_front();
               acc++;
               if (tx_data !== e) begin
                  n_fail++;
                  $display("FAIL read_bit: got %b, expected %b", tx_data, e);
               end
            end
         end
      end
   endtask

   task automatic send_header(input logic [11:0] a, input logic [12:0] b,
                              input bit wr, input bit gaps);
      logic [12:0] ax;
      ax = {1'b0, a};
      for (int i = 0; i < 13; i++) begin
         if (gaps && (i % 4 == 2)) begin
            master_valid = 1'b0;
            rx_address   = ~ax[i];
            rx_burst     = ~b[i];
            tick();
         end
         master_valid = 1'b1;
         read_en      = !wr;
         write_en     = wr;
         rx_address   = ax[i];
         rx_burst     = b[i];
         tick();
      end
      master_valid = 1'b0;
      read_en      = 1'b0;
      write_en     = 1'b0;
   endtask

   task automatic write_words(input logic [11:0] a, input logic [12:0] b,
                              input int n, input bit gaps);
      send_header(a, b, 1'b1, gaps);
      for (int w = 0; w < n; w++) begin
         for (int i = 0; i < 8; i++) begin
            if (gaps && i == 3) begin
               master_valid = 1'b0;
               rx_data      = ~wbuf[w][i];
               tick();
            end
            master_valid = 1'b1;
            rx_data      = wbuf[w][i];
            tick();
         end
      end
      master_valid = 1'b0;
      rx_data      = 1'b0;
      check("wr_done_ready", {31'd0, slave_ready}, 32'd0);
      tick();
      check("wr_idle_ready", {31'd0, slave_ready}, 32'd1);
   endtask

   task automatic read_words(input logic [11:0] a, input logic [12:0] b,
                             input int n, input logic [3:0] pat);
      int start_acc;
      int cyc;
      for (int w = 0; w < n; w++)
         for (int i = 0; i < 8; i++)
            exp_q.push_back(rbuf[w][i]);
      start_acc = acc;
      send_header(a, b, 1'b0, 1'b0);
      cyc = 0;
      while ((acc - start_acc) < 8 * n && cyc < 400) begin
         master_ready = pat[cyc % 4];
         cyc++;
         tick();
      end
      if (cyc >= 400) begin
         n_checks++;
         n_fail++;
         $display("FAIL read_timeout: accepted %0d bits, expected %0d", acc - start_acc, 8 * n);
      end
      // Keep the master ready a few more cycles so surplus bits are caught.
      master_ready = 1'b1;
      repeat (4) tick();
      master_ready = 1'b0;
      check("bits_accepted", acc - start_acc, 8 * n);
      check("rd_idle_ready", {31'd0, slave_ready}, 32'd1);
      check("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         mon_loop();
      join_none

      reset = 1'b1;
      read_en = 1'b0; write_en = 1'b0; master_ready = 1'b0; master_valid = 1'b0;
      rx_done_in = 1'b0; rx_address = 1'b0; rx_burst = 1'b0; rx_data = 1'b0;
      repeat (3) tick();
      check("rst_ready", {31'd0, slave_ready}, 32'd1);
      check("rst_valid", {31'd0, slave_valid}, 32'd0);
      check("rst_tx", {31'd0, tx_data}, 32'd0);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      reset = 1'b0;
      tick();

      // Single write then read of 0xA5.
      wbuf[0] = 8'hA5;
      write_words(12'h005, 13'd1, 1, 1'b0);
      tick();
      rbuf[0] = 8'hA5;
      read_words(12'h005, 13'd1, 1, 4'b1111);

      // Burst across the top of memory.
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      write_words(12'hFFE, 13'd3, 3, 1'b0);
      rbuf[0] = 8'h11; rbuf[1] = 8'h22; rbuf[2] = 8'h33;
      read_words(12'hFFE, 13'd3, 3, 4'b1111);
      rbuf[0] = 8'h33;
      read_words(12'h000, 13'd1, 1, 4'b1111);

      // Read with master_ready stalls (pattern 1,0,0,1).
      rbuf[0] = 8'hA5;
      read_words(12'h005, 13'd1, 1, 4'b1001);

      // Header and data with master_valid gaps.
      wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
      write_words(12'h2A0, 13'd2, 2, 1'b1);
      rbuf[0] = 8'h5A; rbuf[1] = 8'hC3;
      read_words(12'h2A0, 13'd2, 2, 4'b1011);

      // Abort after four write data bits: partial word dropped.
      send_header(12'h005, 13'd1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         master_valid = 1'b1; rx_data = 1'b1; tick();
      end
      rx_done_in = 1'b1; master_valid = 1'b1; rx_data = 1'b1;
      tick();
      check("abort_state", 32'(dut.state), 32'(IDLE));
      check("abort_ready", {31'd0, slave_ready}, 32'd1);
      rx_done_in = 1'b0; master_valid = 1'b0; rx_data = 1'b0;
      tick();
      rbuf[0] = 8'hA5;
      read_words(12'h005, 13'd1, 1, 4'b1111);

      // Asynchronous reset in the middle of a read.
      begin
         int start_acc;
         int cyc;
         for (int i = 0; i < 8; i++) exp_q.push_back(rbuf[0][i]);
         start_acc = acc;
         send_header(12'h005, 13'd1, 1'b0, 1'b0);
         master_ready = 1'b1;
         cyc = 0;
         while ((acc - start_acc) < 3 && cyc < 100) begin
            cyc++;
            tick();
         end
         check("pre_reset_bits", acc - start_acc, 3);
         #1 reset = 1'b1;
         #1;
         check("mid_rst_valid", {31'd0, slave_valid}, 32'd0);
         check("mid_rst_tx", {31'd0, tx_data}, 32'd0);
         check("mid_rst_ready", {31'd0, slave_ready}, 32'd1);
         exp_q.delete();
         master_ready = 1'b0;
         tick();
         reset = 1'b0;
         tick();
      end
      read_words(12'h005, 13'd1, 1, 4'b1111);

      // Illegal start with both enables: must stay idle and not consume bits.
      read_en = 1'b1; write_en = 1'b1; master_valid = 1'b1;
      rx_address = 1'b1; rx_burst = 1'b1;
      tick();
      read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0;
      check("illegal_state", 32'(dut.state), 32'(IDLE));
      check("illegal_ready", {31'd0, slave_ready}, 32'd1);
      rbuf[0] = 8'h22;
      read_words(12'hFFF, 13'd1, 1, 4'b1111);

      // Zero burst count moves exactly one word.
      wbuf[0] = 8'h77;
      write_words(12'h101, 13'd1, 1, 1'b0);
      wbuf[0] = 8'h3C;
      write_words(12'h100, 13'd0, 1, 1'b0);
      rbuf[0] = 8'h3C;
      read_words(12'h100, 13'd0, 1, 4'b1111);
      rbuf[0] = 8'h3C; rbuf[1] = 8'h77;
      read_words(12'h100, 13'd2, 2, 4'b1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
